// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: MM:SS held as four BCD digits, sequenced IDLE/RUN/PAUSE/ADJUST.
// Define ADJ_BLINK_EN to blink the field being adjusted; otherwise digit_blank_o is 0.
module stopwatch_ctrl #(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz_i,
  input  logic       tick_adj_i,
  input  logic       tick_blink_i,
  input  logic       btn_pause_i,
  input  logic       btn_clear_i,
  input  logic       sw_adj_i,
  input  logic       sw_sel_i,
  output logic [3:0] led_0_o,
  output logic [3:0] led_1_o,
  output logic [3:0] led_2_o,
  output logic [3:0] led_3_o,
  output logic [3:0] digit_blank_o,
  output logic       running_o
);

  localparam logic [3:0] MinTensMax  = 4'(MAX_MIN / 10);
  localparam logic [3:0] MinUnitsMax = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StAdjust} state_e;

  state_e     state_q, state_d;
  logic [7:0] sec_q, sec_d;  // {tens, units}
  logic [7:0] min_q, min_d;  // {tens, units}
  logic       running_q;

  function automatic logic [7:0] inc_sec(input logic [7:0] s);
    logic [7:0] r;
    if (s[3:0] != 4'd9)      r = {s[7:4], s[3:0] + 4'd1};
    else if (s[7:4] != 4'd5) r = {s[7:4] + 4'd1, 4'd0};
    else                     r = 8'h00;
    return r;
  endfunction

  function automatic logic [7:0] inc_min(input logic [7:0] m);
    logic [7:0] r;
    if (m == {MinTensMax, MinUnitsMax}) r = 8'h00;
    else if (m[3:0] != 4'd9)            r = {m[7:4], m[3:0] + 4'd1};
    else                                r = {m[7:4] + 4'd1, 4'd0};
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;

    // Actions follow the current state; the next state only affects later cycles.
    unique case (state_q)
      StRun: begin
        if (tick_1hz_i) begin
          sec_d = inc_sec(sec_q);
          if (sec_q == 8'h59) min_d = inc_min(min_q);
        end
      end
      StAdjust: begin
        if (tick_adj_i) begin
          if (sw_sel_i) sec_d = inc_sec(sec_q);
          else          min_d = inc_min(min_q);
        end
      end
      default: ;
    endcase

    if (btn_clear_i) begin
      sec_d = 8'h00;
      min_d = 8'h00;
    end

    if (sw_adj_i)                 state_d = StAdjust;
    else if (state_q == StAdjust) state_d = StPause;
    else if (btn_clear_i)         state_d = StIdle;
    else if (btn_pause_i)         state_d = (state_q == StRun) ? StPause : StRun;
  end

`ifdef ADJ_BLINK_EN
  logic       phase_q, phase_d;
  logic [3:0] blank_q, blank_d;

  always_comb begin
    phase_d = phase_q;
    if (state_q == StAdjust && tick_blink_i) phase_d = ~phase_q;
    if (state_d != StAdjust) phase_d = 1'b0;
    blank_d = 4'b0000;
    if (phase_d) blank_d = sw_sel_i ? 4'b0011 : 4'b1100;
  end

  assign digit_blank_o = blank_q;
`else
  logic unused_tick_blink;
  assign unused_tick_blink = tick_blink_i;
  assign digit_blank_o     = 4'b0000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sec_q     <= 8'h00;
      min_q     <= 8'h00;
      running_q <= 1'b0;
`ifdef ADJ_BLINK_EN
      phase_q   <= 1'b0;
      blank_q   <= 4'b0000;
`endif
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      running_q <= (state_d == StRun);
`ifdef ADJ_BLINK_EN
      phase_q   <= phase_d;
      blank_q   <= blank_d;
`endif
    end
  end

  assign led_0_o   = min_q[7:4];
  assign led_1_o   = min_q[3:0];
  assign led_2_o   = sec_q[7:4];
  assign led_3_o   = sec_q[3:0];
  assign running_o = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: scripted vector table, corner-case sequences
// and randomized stimulus against a seconds-count reference model.
module tb_stopwatch_ctrl;

  localparam int unsigned MaxMin = 59;
  localparam int Period = (MaxMin + 1) * 60;
`ifdef ADJ_BLINK_EN
  localparam bit BlinkOn = 1'b1;
`else
  localparam bit BlinkOn = 1'b0;
`endif

  logic       clk, rst_n;
  logic       tick_1hz, tick_adj, tick_blink, btn_pause, btn_clear, sw_adj, sw_sel;
  logic [3:0] led_0, led_1, led_2, led_3, digit_blank;
  logic       running;

  int total = 0;
  int bad   = 0;

  stopwatch_ctrl #(.MAX_MIN(MaxMin)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_1hz_i   (tick_1hz),
    .tick_adj_i   (tick_adj),
    .tick_blink_i (tick_blink),
    .btn_pause_i  (btn_pause),
    .btn_clear_i  (btn_clear),
    .sw_adj_i     (sw_adj),
    .sw_sel_i     (sw_sel),
    .led_0_o      (led_0),
    .led_1_o      (led_1),
    .led_2_o      (led_2),
    .led_3_o      (led_3),
    .digit_blank_o(digit_blank),
    .running_o    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: time as a plain count of seconds.
  typedef enum int {MIdle, MRun, MPause, MAdj} mstate_e;
  mstate_e    m_state;
  int         m_t;
  bit         m_phase;
  logic [3:0] m_blank;

  function automatic logic [15:0] bcd_of(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_state = MIdle;
    m_t     = 0;
    m_phase = 1'b0;
    m_blank = 4'b0000;
  endtask

  task automatic model_step(input bit p, c, t1, ta, tb, adj, sel);
    int      mins, secs, nt;
    mstate_e ns;
    bit      nph;
    mins = m_t / 60;
    secs = m_t % 60;
    nt   = m_t;
    ns   = m_state;
    nph  = m_phase;
    if (m_state == MRun && t1) nt = (m_t + 1) % Period;
    if (m_state == MAdj && ta) begin
      if (sel) nt = mins * 60 + (secs + 1) % 60;
      else     nt = ((mins + 1) % (MaxMin + 1)) * 60 + secs;
    end
    if (c) nt = 0;
    if (adj)                  ns = MAdj;
    else if (m_state == MAdj) ns = MPause;
    else if (c)               ns = MIdle;
    else if (p)               ns = (m_state == MRun) ? MPause : MRun;
    if (BlinkOn && m_state == MAdj && tb) nph = !m_phase;
    if (ns != MAdj) nph = 1'b0;
    m_t     = nt;
    m_state = ns;
    m_phase = nph;
    m_blank = nph ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_time(input string name, input int exp_t);
    check(name, {16'h0, led_0, led_1, led_2, led_3}, {16'h0, bcd_of(exp_t)});
  endtask

  // One clock with the given pulses; levels sw_adj/sw_sel are held by the caller.
  task automatic cyc(input bit p, c, t1, ta, tb);
    btn_pause  = p;
    btn_clear  = c;
    tick_1hz   = t1;
    tick_adj   = ta;
    tick_blink = tb;
    model_step(p, c, t1, ta, tb, sw_adj, sw_sel);
    @(posedge clk);
    #1;
    btn_pause  = 1'b0;
    btn_clear  = 1'b0;
    tick_1hz   = 1'b0;
    tick_adj   = 1'b0;
    tick_blink = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_time("reset_digits", 0);
    check("reset_running", {31'h0, running}, 32'h0);
    check("reset_blank", {28'h0, digit_blank}, 32'h0);
    #10;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit p, c, t1, ta, adj, sel;
    int exp_t;
    bit exp_run;
  } vec_t;

  vec_t vecs[15];

  initial begin
    rst_n = 1'b1; tick_1hz = 0; tick_adj = 0; tick_blink = 0;
    btn_pause = 0; btn_clear = 0; sw_adj = 0; sw_sel = 0;

    vecs[0]  = '{p:1, c:0, t1:0, ta:0, adj:0, sel:0, exp_t:0,  exp_run:1};
    vecs[1]  = '{p:0, c:0, t1:1, ta:0, adj:0, sel:0, exp_t:1,  exp_run:1};
    vecs[2]  = '{p:1, c:0, t1:1, ta:0, adj:0, sel:0, exp_t:2,  exp_run:0};
    vecs[3]  = '{p:0, c:0, t1:1, ta:0, adj:0, sel:0, exp_t:2,  exp_run:0};
    vecs[4]  = '{p:1, c:0, t1:0, ta:0, adj:0, sel:0, exp_t:2,  exp_run:1};
    vecs[5]  = '{p:0, c:1, t1:0, ta:0, adj:0, sel:0, exp_t:0,  exp_run:0};
    vecs[6]  = '{p:0, c:0, t1:0, ta:1, adj:1, sel:0, exp_t:0,  exp_run:0};
    vecs[7]  = '{p:0, c:0, t1:0, ta:1, adj:1, sel:0, exp_t:60, exp_run:0};
    vecs[8]  = '{p:0, c:0, t1:0, ta:1, adj:1, sel:1, exp_t:61, exp_run:0};
    vecs[9]  = '{p:0, c:0, t1:1, ta:0, adj:1, sel:1, exp_t:61, exp_run:0};
    vecs[10] = '{p:1, c:0, t1:0, ta:0, adj:0, sel:0, exp_t:61, exp_run:0};
    vecs[11] = '{p:1, c:0, t1:0, ta:0, adj:0, sel:0, exp_t:61, exp_run:1};
    vecs[12] = '{p:0, c:0, t1:1, ta:0, adj:0, sel:0, exp_t:62, exp_run:1};
    vecs[13] = '{p:0, c:1, t1:1, ta:0, adj:1, sel:0, exp_t:0,  exp_run:0};
    vecs[14] = '{p:0, c:0, t1:0, ta:0, adj:0, sel:0, exp_t:0,  exp_run:0};

    // Vector table
    do_reset();
    for (int i = 0; i < 15; i++) begin
      sw_adj = vecs[i].adj;
      sw_sel = vecs[i].sel;
      cyc(vecs[i].p, vecs[i].c, vecs[i].t1, vecs[i].ta, 1'b0);
      check($sformatf("vec%0d_digits", i), {16'h0, led_0, led_1, led_2, led_3},
            {16'h0, bcd_of(vecs[i].exp_t)});
      check($sformatf("vec%0d_running", i), {31'h0, running}, {31'h0, vecs[i].exp_run});
      check($sformatf("vec%0d_blank", i), {28'h0, digit_blank}, 32'h0);
    end
    sw_adj = 0; sw_sel = 0;

    // Count 65 seconds
    do_reset();
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 65; i++) cyc(0, 0, 1, 0, 0);
    check_time("count_65", 65);
    check("count_65_running", {31'h0, running}, 32'h1);

    // 59:59 wraps to 00:00 in RUN
    do_reset();
    sw_adj = 1; cyc(0, 0, 0, 0, 0);
    sw_sel = 0; for (int i = 0; i < 59; i++) cyc(0, 0, 0, 1, 0);
    sw_sel = 1; for (int i = 0; i < 59; i++) cyc(0, 0, 0, 1, 0);
    check_time("preload_5959", 59 * 60 + 59);
    sw_adj = 0; sw_sel = 0; cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check_time("wrap_run", 0);
    check("wrap_running", {31'h0, running}, 32'h1);

    // Tick together with pause is counted
    do_reset();
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0);
    check_time("at_10", 10);
    cyc(1, 0, 1, 0, 0);
    check_time("pause_tick", 11);
    check("pause_tick_running", {31'h0, running}, 32'h0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    check_time("paused_ticks", 11);

    // Seconds adjust wraps without carry
    do_reset();
    sw_adj = 1; sw_sel = 1; cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 58; i++) cyc(0, 0, 0, 1, 0);
    check_time("adj_58", 58);
    cyc(0, 0, 0, 1, 0);
    check_time("adj_59", 59);
    cyc(0, 0, 0, 1, 0);
    check_time("adj_wrap", 0);
    for (int i = 0; i < 59; i++) cyc(0, 0, 0, 1, 0);
    check_time("adj_61_steps", 59);
    sw_adj = 0; sw_sel = 0; cyc(0, 0, 0, 0, 0);

    // Clear from PAUSE and clear overriding a tick in RUN
    do_reset();
    sw_adj = 1; cyc(0, 0, 0, 0, 0);
    sw_sel = 0; for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 0);
    sw_sel = 1; for (int i = 0; i < 34; i++) cyc(0, 0, 0, 1, 0);
    sw_adj = 0; sw_sel = 0; cyc(0, 0, 0, 0, 0);
    check_time("pause_1234", 12 * 60 + 34);
    cyc(0, 1, 0, 0, 0);
    check_time("clear_pause", 0);
    check("clear_pause_running", {31'h0, running}, 32'h0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check_time("run_2", 2);
    cyc(0, 1, 1, 0, 0);
    check_time("clear_tick", 0);
    check("clear_tick_running", {31'h0, running}, 32'h0);

    // Blink and asynchronous reset
    do_reset();
    sw_adj = 1; sw_sel = 0; cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("blink_on_min", {28'h0, digit_blank}, {28'h0, BlinkOn ? 4'b1100 : 4'b0000});
    cyc(0, 0, 0, 0, 1);
    check("blink_off", {28'h0, digit_blank}, 32'h0);
    cyc(0, 0, 0, 0, 1);
    sw_sel = 1; cyc(0, 0, 0, 0, 0);
    check("blink_on_sec", {28'h0, digit_blank}, {28'h0, BlinkOn ? 4'b0011 : 4'b0000});
    sw_adj = 0; sw_sel = 0; cyc(0, 0, 0, 0, 0);
    check("blink_exit", {28'h0, digit_blank}, 32'h0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    check_time("pre_reset", 3);
    do_reset();

    // Randomized run against the model
    begin
      bit r_adj, r_sel;
      r_adj = 0; r_sel = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 29) == 0) r_adj = !r_adj;
        if ($urandom_range(0, 4) == 0)  r_sel = !r_sel;
        sw_adj = r_adj;
        sw_sel = r_sel;
        cyc($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        check("rand_digits", {16'h0, led_0, led_1, led_2, led_3}, {16'h0, bcd_of(m_t)});
        check("rand_running", {31'h0, running}, {31'h0, m_state == MRun});
        check("rand_blank", {28'h0, digit_blank}, {28'h0, m_blank});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
